// File: rtl/stopwatch_bcd_core_if.sv
// stopwatch_bcd_core_if
// Groups the run-control inputs and the BCD display outputs of the
// stopwatch core. The slave modport is taken by the core. The master
// modport is taken by whatever drives the core and reads its digits.
// Optional macro STOPWATCH_LAP_EN adds the lap input.

interface stopwatch_bcd_core_if;
    logic       tick;
    logic       start_stop;
    logic       clr;
`ifdef STOPWATCH_LAP_EN
    logic       lap;
`endif
    logic [3:0] hund;
    logic [3:0] tenth;
    logic [3:0] sec_one;
    logic [3:0] sec_ten;
    logic       running;
    logic       wrap;

    modport slave (
`ifdef STOPWATCH_LAP_EN
        input  lap,
`endif
        input  tick,
        input  start_stop,
        input  clr,
        output hund,
        output tenth,
        output sec_one,
        output sec_ten,
        output running,
        output wrap
    );

    modport master (
`ifdef STOPWATCH_LAP_EN
        output lap,
`endif
        output tick,
        output start_stop,
        output clr,
        input  hund,
        input  tenth,
        input  sec_one,
        input  sec_ten,
        input  running,
        input  wrap
    );
endinterface

// File: rtl/stopwatch_bcd_core.sv
// stopwatch_bcd_core
// Counts 1/100 s ticks into four BCD digits (SS.hh) under a small
// IDLE/RUN/STOP run-control FSM.
// - The start/stop button level is edge-detected, so holding it toggles
//   the FSM only once.
// - clr is a synchronous level. It zeroes the digits and returns the FSM
//   to IDLE, and it outranks both a tick and a button edge.
// - wrap pulses for one cycle when the count rolls over to 00.00.
// Optional macro STOPWATCH_LAP_EN adds a lap input and a display hold
// register. When the macro is undefined, the outputs are the live digits.

module stopwatch_bcd_core #(
    parameter int SEC_TENS_MAX = 5,
    parameter int TICK_GATE    = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    stopwatch_bcd_core_if.slave   bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_STOP = 2'd2
    } state_e;

    localparam logic [3:0] DIG_MAX  = 4'd9;
    localparam logic [3:0] TENS_MAX = 4'(SEC_TENS_MAX);

    // Advances one BCD digit. Any value at or above the digit's maximum,
    // including an out-of-range value left by an upset, becomes 0.
    function automatic logic [3:0] bcd_step(input logic [3:0] d, input logic [3:0] max);
        logic [3:0] r;
        if (d >= max) begin
            r = 4'd0;
        end else begin
            r = d + 4'd1;
        end
        return r;
    endfunction

    state_e     state_q, state_d;
    logic       running_q, running_d;
    logic       ss_prev_q, ss_prev_d;
    logic [3:0] hund_q, hund_d;
    logic [3:0] tenth_q, tenth_d;
    logic [3:0] sec_one_q, sec_one_d;
    logic [3:0] sec_ten_q, sec_ten_d;
    logic       wrap_q, wrap_d;
    logic       ss_rise;
    logic       cnt_en;

    // Button rising edge and tick qualification.
    // Both use the state as it stands before this edge.
    always_comb begin
        ss_rise   = bus.start_stop & ~ss_prev_q;
        ss_prev_d = bus.start_stop;
        if (TICK_GATE != 0) begin
            cnt_en = bus.tick & (state_q == ST_RUN);
        end else begin
            cnt_en = bus.tick & (state_q != ST_IDLE);
        end
    end

    // Run-control next state.
    // clr has priority over a button edge in the same cycle.
    always_comb begin
        state_d = state_q;
        if (bus.clr) begin
            state_d = ST_IDLE;
        end else if (ss_rise) begin
            case (state_q)
                ST_IDLE: state_d = ST_RUN;
                ST_RUN:  state_d = ST_STOP;
                ST_STOP: state_d = ST_RUN;
                default: state_d = ST_IDLE;
            endcase
        end else begin
            state_d = state_q;
        end
        running_d = (state_d == ST_RUN);
    end

    // Ripple-enabled BCD digit chain.
    // Each digit advances only when every lower digit is at its maximum.
    always_comb begin
        hund_d    = hund_q;
        tenth_d   = tenth_q;
        sec_one_d = sec_one_q;
        sec_ten_d = sec_ten_q;
        wrap_d    = 1'b0;
        if (bus.clr) begin
            hund_d    = 4'd0;
            tenth_d   = 4'd0;
            sec_one_d = 4'd0;
            sec_ten_d = 4'd0;
        end else if (cnt_en) begin
            hund_d = bcd_step(hund_q, DIG_MAX);
            if (hund_q == DIG_MAX) begin
                tenth_d = bcd_step(tenth_q, DIG_MAX);
                if (tenth_q == DIG_MAX) begin
                    sec_one_d = bcd_step(sec_one_q, DIG_MAX);
                    if (sec_one_q == DIG_MAX) begin
                        sec_ten_d = bcd_step(sec_ten_q, TENS_MAX);
                        if (sec_ten_q == TENS_MAX) begin
                            wrap_d = 1'b1;
                        end else begin
                            wrap_d = 1'b0;
                        end
                    end else begin
                        sec_ten_d = sec_ten_q;
                    end
                end else begin
                    sec_one_d = sec_one_q;
                end
            end else begin
                tenth_d = tenth_q;
            end
        end else begin
            hund_d = hund_q;
        end
    end

    // State, edge-detect and counter registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            running_q <= 1'b0;
            ss_prev_q <= 1'b0;
            hund_q    <= 4'd0;
            tenth_q   <= 4'd0;
            sec_one_q <= 4'd0;
            sec_ten_q <= 4'd0;
            wrap_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            running_q <= running_d;
            ss_prev_q <= ss_prev_d;
            hund_q    <= hund_d;
            tenth_q   <= tenth_d;
            sec_one_q <= sec_one_d;
            sec_ten_q <= sec_ten_d;
            wrap_q    <= wrap_d;
        end
    end

`ifdef STOPWATCH_LAP_EN
    logic       lap_prev_q, lap_prev_d;
    logic       lap_hold_q, lap_hold_d;
    logic [3:0] disp_hund_q, disp_hund_d;
    logic [3:0] disp_tenth_q, disp_tenth_d;
    logic [3:0] disp_sec_one_q, disp_sec_one_d;
    logic [3:0] disp_sec_ten_q, disp_sec_ten_d;
    logic       lap_rise;

    // Lap hold control.
    // A lap edge in RUN freezes the current digits.
    // A second lap edge, a button edge or clr releases the hold.
    always_comb begin
        lap_rise       = bus.lap & ~lap_prev_q;
        lap_prev_d     = bus.lap;
        lap_hold_d     = lap_hold_q;
        disp_hund_d    = disp_hund_q;
        disp_tenth_d   = disp_tenth_q;
        disp_sec_one_d = disp_sec_one_q;
        disp_sec_ten_d = disp_sec_ten_q;
        if (bus.clr || ss_rise) begin
            lap_hold_d = 1'b0;
        end else if (lap_rise) begin
            if (lap_hold_q) begin
                lap_hold_d = 1'b0;
            end else if (state_q == ST_RUN) begin
                lap_hold_d     = 1'b1;
                disp_hund_d    = hund_q;
                disp_tenth_d   = tenth_q;
                disp_sec_one_d = sec_one_q;
                disp_sec_ten_d = sec_ten_q;
            end else begin
                lap_hold_d = lap_hold_q;
            end
        end else begin
            lap_hold_d = lap_hold_q;
        end
    end

    // Lap edge-detect, hold flag and display register.
    always_ff @(posedge clk) begin
        if (rst) begin
            lap_prev_q     <= 1'b0;
            lap_hold_q     <= 1'b0;
            disp_hund_q    <= 4'd0;
            disp_tenth_q   <= 4'd0;
            disp_sec_one_q <= 4'd0;
            disp_sec_ten_q <= 4'd0;
        end else begin
            lap_prev_q     <= lap_prev_d;
            lap_hold_q     <= lap_hold_d;
            disp_hund_q    <= disp_hund_d;
            disp_tenth_q   <= disp_tenth_d;
            disp_sec_one_q <= disp_sec_one_d;
            disp_sec_ten_q <= disp_sec_ten_d;
        end
    end

    assign bus.hund    = lap_hold_q ? disp_hund_q    : hund_q;
    assign bus.tenth   = lap_hold_q ? disp_tenth_q   : tenth_q;
    assign bus.sec_one = lap_hold_q ? disp_sec_one_q : sec_one_q;
    assign bus.sec_ten = lap_hold_q ? disp_sec_ten_q : sec_ten_q;
`else
    assign bus.hund    = hund_q;
    assign bus.tenth   = tenth_q;
    assign bus.sec_one = sec_one_q;
    assign bus.sec_ten = sec_ten_q;
`endif

    // wrap always follows the live counter, even while a lap is displayed.
    assign bus.running = running_q;
    assign bus.wrap    = wrap_q;

endmodule
